// File: rtl/pio_imem_pkg.sv
// Shared types and sizes for the PIO instruction-memory arbiter.
package pio_imem_pkg;

    localparam int IMEM_DEPTH  = 32;
    localparam int IMEM_ADDR_W = 5;
    localparam int IMEM_DATA_W = 16;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_WRITE,
        PH_READ
    } imem_phase_t;

    typedef logic [IMEM_ADDR_W-1:0] imem_addr_t;

endpackage

// File: rtl/pio_imem_arbiter_rr.sv
// Round-robin picker: grants the first eligible (req & mask) requester at or after ptr, cyclically.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx
);

    logic [N-1:0] eligible;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elig
            assign eligible[gi] = req[gi] & mask[gi];
        end
    endgenerate

    always_comb begin
        int   cand;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            if (!found && eligible[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/pio_imem_arbiter.sv
// Single-port instruction RAM arbiter: bus writes first, SM fetches round-robin, one access per cycle.
// Optional macro PIO_IMEM_WR_FAIR_EN alternates writes with fetches while SMs are waiting.
module pio_imem_arbiter
    import pio_imem_pkg::*;
#(
    parameter int NUM_SM = 4,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bus_wr,
    input  logic [ADDR_W-1:0]        bus_waddr,
    input  logic [DATA_W-1:0]        bus_wdata,
    output logic                     bus_wr_ack,
    input  logic [NUM_SM-1:0]        sm_req,
    input  logic [NUM_SM*ADDR_W-1:0] sm_addr,
    input  logic [NUM_SM-1:0]        sm_flush,
    output logic [NUM_SM-1:0]        sm_gnt,
    output logic [NUM_SM-1:0]        sm_rvalid,
    output logic [DATA_W-1:0]        sm_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_wr,
    output logic                     mem_rd,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy
);

    localparam int PTR_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

    logic [PTR_W-1:0]  rr_ptr_reg;
    logic              rd_pend_reg;
    logic [PTR_W-1:0]  rd_owner_reg;
    logic [NUM_SM-1:0] sm_rvalid_reg;
    logic [DATA_W-1:0] sm_rdata_reg;

    logic [ADDR_W-1:0] addr_arr [NUM_SM];
    logic [NUM_SM-1:0] arb_gnt;
    logic [PTR_W-1:0]  arb_idx;
    logic              wr_allowed;
    imem_phase_t       phase;

    generate
        for (genvar gi = 0; gi < NUM_SM; gi++) begin : g_addr
            assign addr_arr[gi] = sm_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // A flushing SM is masked so a restart never gets a stale fetch granted.
    rr_arbiter #(.N(NUM_SM)) u_rr (
        .req  (sm_req),
        .mask (~sm_flush),
        .ptr  (rr_ptr_reg),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

`ifdef PIO_IMEM_WR_FAIR_EN
    logic last_was_wr_reg;

    assign wr_allowed = bus_wr && !(last_was_wr_reg && (|(sm_req & ~sm_flush)));

    always_ff @(posedge clk) begin
        if (reset) last_was_wr_reg <= 1'b0;
        else       last_was_wr_reg <= (phase == PH_WRITE);
    end
`else
    assign wr_allowed = bus_wr;
`endif

    always_comb begin
        if (wr_allowed)    phase = PH_WRITE;
        else if (|arb_gnt) phase = PH_READ;
        else               phase = PH_IDLE;
    end

    always_comb begin
        bus_wr_ack = 1'b0;
        sm_gnt     = '0;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (phase)
            PH_WRITE: begin
                bus_wr_ack = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = bus_waddr;
                mem_wdata  = bus_wdata;
            end
            PH_READ: begin
                sm_gnt   = arb_gnt;
                mem_rd   = 1'b1;
                mem_addr = addr_arr[arb_idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg    <= '0;
            rd_pend_reg   <= 1'b0;
            rd_owner_reg  <= '0;
            sm_rvalid_reg <= '0;
            sm_rdata_reg  <= '0;
        end else begin
            if (phase == PH_READ) begin
                rr_ptr_reg   <= (arb_idx == PTR_W'(NUM_SM-1)) ? '0 : arb_idx + 1'b1;
                rd_owner_reg <= arb_idx;
            end
            rd_pend_reg <= (phase == PH_READ);
            // RAM data arrives the cycle after the grant; a flush by the owner drops it here.
            sm_rvalid_reg <= '0;
            if (rd_pend_reg && !sm_flush[rd_owner_reg])
                sm_rvalid_reg[rd_owner_reg] <= 1'b1;
            if (rd_pend_reg)
                sm_rdata_reg <= mem_rdata;
        end
    end

    assign sm_rvalid = sm_rvalid_reg;
    assign sm_rdata  = sm_rdata_reg;
    assign busy      = bus_wr | (|sm_req) | rd_pend_reg;

endmodule

// File: tb/tb_pio_imem_arbiter.sv
// Directed bench for pio_imem_arbiter with a behavioural single-port RAM attached.
module tb_pio_imem_arbiter;

    localparam int NUM_SM = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     bus_wr;
    logic [ADDR_W-1:0]        bus_waddr;
    logic [DATA_W-1:0]        bus_wdata;
    logic                     bus_wr_ack;
    logic [NUM_SM-1:0]        sm_req;
    logic [NUM_SM*ADDR_W-1:0] sm_addr;
    logic [NUM_SM-1:0]        sm_flush;
    logic [NUM_SM-1:0]        sm_gnt;
    logic [NUM_SM-1:0]        sm_rvalid;
    logic [DATA_W-1:0]        sm_rdata;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_wr;
    logic                     mem_rd;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     busy;

    logic [DATA_W-1:0] ram [32];

    int total = 0;
    int bad   = 0;
    int acks  = 0;
    int gnts  = 0;

    pio_imem_arbiter #(.NUM_SM(NUM_SM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_wr     (bus_wr),
        .bus_waddr  (bus_waddr),
        .bus_wdata  (bus_wdata),
        .bus_wr_ack (bus_wr_ack),
        .sm_req     (sm_req),
        .sm_addr    (sm_addr),
        .sm_flush   (sm_flush),
        .sm_gnt     (sm_gnt),
        .sm_rvalid  (sm_rvalid),
        .sm_rdata   (sm_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int sm, input logic [ADDR_W-1:0] a);
        sm_addr[sm*ADDR_W +: ADDR_W] = a;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 16'h1000 + 16'(i);
        mem_rdata = '0;
        reset     = 1'b1;
        bus_wr    = 1'b0;
        bus_waddr = '0;
        bus_wdata = '0;
        sm_req    = '0;
        sm_addr   = '0;
        sm_flush  = '0;

        // Reset held two cycles.
        tick();
        tick();
        #1;
        chk("rst_rvalid", sm_rvalid, 0);
        chk("rst_rdata", sm_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", sm_gnt, 0);
        chk("rst_memrd", mem_rd, 0);
        chk("rst_memwr", mem_wr, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ack", bus_wr_ack, 0);
        tick();
        reset = 1'b0;

        // First fetch from SM0 wins with rr_ptr at 0.
        sm_req = 4'b0001; set_addr(0, 5'h02); #1;
        chk("sm0_gnt", sm_gnt, 4'b0001);
        chk("sm0_memrd", mem_rd, 1);
        chk("sm0_addr", mem_addr, 5'h02);
        tick(); sm_req = '0; #1;
        chk("sm0_rv_n1", sm_rvalid, 0);
        chk("sm0_busy_n1", busy, 1);
        tick();
        chk("sm0_rv", sm_rvalid, 4'b0001);
        chk("sm0_rdata", sm_rdata, 16'h1002);
        chk("sm0_busy_n2", busy, 0);

        // Write 0x03 then SM2 fetches it: rvalid three cycles after the write.
        bus_wr = 1'b1; bus_waddr = 5'h03; bus_wdata = 16'hA0B1; #1;
        chk("wr_ack", bus_wr_ack, 1);
        chk("wr_memwr", mem_wr, 1);
        chk("wr_addr", mem_addr, 5'h03);
        chk("wr_data", mem_wdata, 16'hA0B1);
        chk("wr_gnt", sm_gnt, 0);
        tick(); bus_wr = 1'b0; sm_req = 4'b0100; set_addr(2, 5'h03); #1;
        chk("sm2_gnt", sm_gnt, 4'b0100);
        chk("sm2_addr", mem_addr, 5'h03);
        tick(); sm_req = '0;
        tick();
        chk("sm2_rv", sm_rvalid, 4'b0100);
        chk("sm2_rdata", sm_rdata, 16'hA0B1);

        // Reset mid-operation drops the read of SM1 and rewinds rr_ptr.
        sm_req = 4'b0010; set_addr(1, 5'h01); #1;
        chk("mid_gnt", sm_gnt, 4'b0010);
        tick(); sm_req = '0; reset = 1'b1;
        tick(); reset = 1'b0; #1;
        chk("mid_rv", sm_rvalid, 0);
        chk("mid_busy", busy, 0);
        tick();
        chk("mid_rv2", sm_rvalid, 0);

        // All four requesting for 8 cycles: grants 0..3 twice, rvalid two cycles behind.
        for (int k = 0; k < 4; k++) set_addr(k, 5'(8 + k));
        for (int c = 0; c < 10; c++) begin
            sm_req = (c < 8) ? 4'b1111 : 4'b0000; #1;
            if (c < 8) begin
                chk("rr_gnt", sm_gnt, 32'(1 << (c % 4)));
                chk("rr_addr", mem_addr, 32'(8 + c % 4));
            end
            if (c >= 2) begin
                chk("rr_rv", sm_rvalid, 32'(1 << ((c - 2) % 4)));
                chk("rr_rdata", sm_rdata, 32'(16'h1008 + (c - 2) % 4));
            end else begin
                chk("rr_rv_idle", sm_rvalid, 0);
            end
            tick();
        end

        // Write and SM1 fetch to 0x07 together: write wins, SM1 reads new data.
        bus_wr = 1'b1; bus_waddr = 5'h07; bus_wdata = 16'h5A5A;
        sm_req = 4'b0010; set_addr(1, 5'h07); #1;
        chk("same_ack", bus_wr_ack, 1);
        chk("same_gnt0", sm_gnt, 0);
        chk("same_memwr", mem_wr, 1);
        tick(); bus_wr = 1'b0; #1;
        chk("same_gnt1", sm_gnt, 4'b0010);
        chk("same_addr", mem_addr, 5'h07);
        chk("same_ack1", bus_wr_ack, 0);
        tick(); sm_req = '0;
        tick();
        chk("same_rv", sm_rvalid, 4'b0010);
        chk("same_rdata", sm_rdata, 16'h5A5A);

        // SM3 granted then flushed: no rvalid, busy falls two cycles after the request.
        sm_req = 4'b1000; set_addr(3, 5'h04); #1;
        chk("fl_gnt", sm_gnt, 4'b1000);
        tick(); sm_req = '0; sm_flush = 4'b1000; #1;
        chk("fl_busy1", busy, 1);
        chk("fl_rv1", sm_rvalid, 0);
        tick(); sm_flush = '0; #1;
        chk("fl_rv2", sm_rvalid, 0);
        chk("fl_busy2", busy, 0);
        tick();
        chk("fl_rv3", sm_rvalid, 0);

        // Flush in the same cycle as a request blocks that grant.
        sm_req = 4'b0001; sm_flush = 4'b0001; set_addr(0, 5'h02); #1;
        chk("flblk_gnt", sm_gnt, 0);
        chk("flblk_rd", mem_rd, 0);
        tick(); sm_flush = '0; #1;
        chk("flblk_gnt2", sm_gnt, 4'b0001);
        tick(); sm_req = '0;
        tick();
        chk("flblk_rv", sm_rvalid, 4'b0001);
        chk("flblk_rdata", sm_rdata, 16'h1002);

        // Bus write held six cycles against a waiting SM0.
        bus_wr = 1'b1; bus_waddr = 5'h0A; bus_wdata = 16'hBEEF;
        sm_req = 4'b0001; set_addr(0, 5'h0A);
        for (int c = 0; c < 6; c++) begin
            #1;
`ifdef PIO_IMEM_WR_FAIR_EN
            chk("fair_ack", bus_wr_ack, (c % 2 == 0) ? 1 : 0);
            chk("fair_gnt", sm_gnt, (c % 2 == 1) ? 4'b0001 : 4'b0000);
`else
            chk("prio_ack", bus_wr_ack, 1);
            chk("prio_gnt", sm_gnt, 0);
`endif
            if (bus_wr_ack) acks++;
            if (sm_gnt[0]) gnts++;
            tick();
        end
        bus_wr = 1'b0; #1;
        chk("wr_end_gnt", sm_gnt, 4'b0001);
`ifdef PIO_IMEM_WR_FAIR_EN
        chk("fair_acks", acks, 3);
        chk("fair_gnts", gnts, 3);
`else
        chk("prio_acks", acks, 6);
        chk("prio_gnts", gnts, 0);
`endif
        tick(); sm_req = '0;
        tick();
        chk("wr_end_rv", sm_rvalid, 4'b0001);
        chk("wr_end_rdata", sm_rdata, 16'hBEEF);
        tick();
        chk("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
